// File: rtl/moore_101.sv
// Moore-type detector for the serial pattern 1-0-1, with overlapping matches allowed.
// Optional build macro MOORE101_COUNT_EN adds a saturating 8-bit detection counter on port count.
module moore_101 (
    input  logic       clk,
    input  logic       reset,
    input  logic       x,
`ifdef MOORE101_COUNT_EN
    output logic [7:0] count,
`endif
    output logic       y
);

    typedef enum logic [1:0] {
        S0   = 2'b00,
        S1   = 2'b01,
        S10  = 2'b10,
        S101 = 2'b11
    } state_t;

    state_t state;
    state_t nextState;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S0;
        end else begin
            state <= nextState;
        end
    end

    // From S101 the trailing 1 is reused as the first bit of the next match.
    always_comb begin
        nextState = state;
        unique case (state)
            S0:   nextState = x ? S1   : S0;
            S1:   nextState = x ? S1   : S10;
            S10:  nextState = x ? S101 : S0;
            S101: nextState = x ? S1   : S10;
            default: nextState = S0;
        endcase
    end

    assign y = (state == S101);

`ifdef MOORE101_COUNT_EN
    // Counting on nextState keeps count in step with the edge that raises y.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 8'd0;
        end else if ((nextState == S101) && (count != 8'hFF)) begin
            count <= count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_moore_101.sv
// Directed self-checking bench for moore_101; count checks are compiled in with MOORE101_COUNT_EN.
module tb_moore_101;

    logic       clk;
    logic       reset;
    logic       x;
    logic       y;
`ifdef MOORE101_COUNT_EN
    logic [7:0] count;
`endif

    int errors;
    int checks;

    moore_101 dut (
        .clk   (clk),
        .reset (reset),
        .x     (x),
`ifdef MOORE101_COUNT_EN
        .count (count),
`endif
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one bit, lets one rising edge pass, then samples 1 time unit later.
    task automatic applyStimulus(input logic b);
        x = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [2:0] seq;
        logic [2:0] expY;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'($urandom_range(0, 1)));
            checks++;
            if (y !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_y%0d: y=%0b expected 0", i, y);
            end
        end
`ifdef MOORE101_COUNT_EN
        checks++;
        if (count !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_count: count=%0d expected 0", count);
        end
`endif
        reset = 1'b0;
        seq  = 3'b101;
        expY = 3'b001;
        for (int i = 2; i >= 0; i--) begin
            applyStimulus(seq[i]);
            checks++;
            if (y !== expY[i]) begin
                errors++;
                $display("[TB] FAIL release_bit%0d: y=%0b expected %0b", 2 - i, y, expY[i]);
            end
        end
    endtask

    task automatic test_reference_stream;
        logic [19:0] stream;
        logic [19:0] expY;
        int pulses;
        stream = 20'b0101_0101_0010_1010_0101;
        expY   = 20'b0001_0101_0000_1010_0001;
        pulses = 0;
        reset = 1'b1;
        applyStimulus(1'b0);
        reset = 1'b0;
        for (int i = 19; i >= 0; i--) begin
            applyStimulus(stream[i]);
            if (y === 1'b1) pulses++;
            checks++;
            if (y !== expY[i]) begin
                errors++;
                $display("[TB] FAIL ref_bit%0d: y=%0b expected %0b", 20 - i, y, expY[i]);
            end
        end
        checks++;
        if (pulses != 6) begin
            errors++;
            $display("[TB] FAIL ref_pulses: got %0d expected 6", pulses);
        end
`ifdef MOORE101_COUNT_EN
        checks++;
        if (count !== 8'd6) begin
            errors++;
            $display("[TB] FAIL ref_count: count=%0d expected 6", count);
        end
`endif
    endtask

    task automatic test_non_match;
        logic [3:0] seqA;
        logic [4:0] seqB;
        logic [4:0] expB;
        seqA = 4'b1001;
        for (int i = 3; i >= 0; i--) begin
            applyStimulus(seqA[i]);
            checks++;
            if (y !== 1'b0) begin
                errors++;
                $display("[TB] FAIL nomatch_1001_bit%0d: y=%0b expected 0", 3 - i, y);
            end
        end
        seqB = 5'b11101;
        expB = 5'b00001;
        for (int i = 4; i >= 0; i--) begin
            applyStimulus(seqB[i]);
            checks++;
            if (y !== expB[i]) begin
                errors++;
                $display("[TB] FAIL seq_11101_bit%0d: y=%0b expected %0b", 4 - i, y, expB[i]);
            end
        end
    endtask

    task automatic test_reset_mid_match;
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        reset = 1'b1;
        applyStimulus(1'b1);
        reset = 1'b0;
        checks++;
        if (y !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_during: y=%0b expected 0", y);
        end
        applyStimulus(1'b1);
        checks++;
        if (y !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_after1: y=%0b expected 0", y);
        end
        applyStimulus(1'b0);
        checks++;
        if (y !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_after0: y=%0b expected 0", y);
        end
        applyStimulus(1'b1);
        checks++;
        if (y !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_pulse: y=%0b expected 1", y);
        end
        applyStimulus(1'b1);
        checks++;
        if (y !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_width: y=%0b expected 0", y);
        end
    endtask

    task automatic test_back_to_back;
        logic prevY;
        reset = 1'b1;
        applyStimulus(1'b0);
        reset = 1'b0;
        prevY = 1'b0;
        for (int r = 0; r < 300; r++) begin
            applyStimulus(1'b1);
            checks++;
            if (y !== (r > 0)) begin
                errors++;
                $display("[TB] FAIL b2b_one_rep%0d: y=%0b expected %0b", r, y, (r > 0));
            end
            if (prevY === 1'b1 && y === 1'b1) begin
                errors++;
                $display("[TB] FAIL b2b_width_rep%0d: y high two cycles", r);
            end
            prevY = y;
            applyStimulus(1'b0);
            checks++;
            if (y !== 1'b0) begin
                errors++;
                $display("[TB] FAIL b2b_zero_rep%0d: y=%0b expected 0", r, y);
            end
            prevY = y;
        end
`ifdef MOORE101_COUNT_EN
        checks++;
        if (count !== 8'd255) begin
            errors++;
            $display("[TB] FAIL sat_count: count=%0d expected 255", count);
        end
        reset = 1'b1;
        applyStimulus(1'b1);
        reset = 1'b0;
        checks++;
        if (count !== 8'd0) begin
            errors++;
            $display("[TB] FAIL sat_clear: count=%0d expected 0", count);
        end
`endif
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        x      = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_non_match();
        test_reset_mid_match();
        test_reference_stream();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
